// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: byte-serial multi-byte compare through one cascadable 8-bit comparator slice (signed build: SIGNED_EN).
// Latency: start sampled in cycle 0, BYTES RUN cycles, done pulse with EQ/GT in cycle BYTES+1.
// Backpressure: start is ignored while busy; a start in the DONE cycle restarts back-to-back.
module cmp_seq_ctrl #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*BYTES-1:0] A,
  input  logic [8*BYTES-1:0] B,
  output logic               busy,
  output logic               done,
  output logic               EQ,
  output logic               GT,
  output logic [7:0]         slice_A,
  output logic [7:0]         slice_B,
  output logic               slice_eq,
  output logic               slice_gt,
  input  logic               slice_EQ,
  input  logic               slice_GT
);

  localparam int W  = 8 * BYTES;
  localparam int IW = $clog2(BYTES) + 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          acc_eq;
  logic          acc_gt;
  logic [W-1:0]  a_lat;
  logic [W-1:0]  b_lat;
  logic [7:0]    sel_a;
  logic [7:0]    sel_b;

  // Slice drive decodes only from registered state, never from slice_EQ/GT.
  always_comb begin
    sel_a = 8'h00;
    sel_b = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (idx == IW'(i)) begin
        sel_a = a_lat[8*i +: 8];
        sel_b = b_lat[8*i +: 8];
      end
    end
    slice_A  = 8'h00;
    slice_B  = 8'h00;
    slice_eq = 1'b1;
    slice_gt = 1'b0;
    if (state == S_RUN) begin
      slice_A  = sel_a;
      slice_B  = sel_b;
      slice_eq = acc_eq;
      slice_gt = acc_gt;
`ifdef SIGNED_EN
      // Offset-binary on the top byte turns the unsigned slice into a signed compare.
      if (idx == LAST) begin
        slice_A[7] = ~a_lat[W-1];
        slice_B[7] = ~b_lat[W-1];
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      acc_eq <= 1'b1;
      acc_gt <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      EQ     <= 1'b0;
      GT     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          acc_eq <= slice_EQ;
          acc_gt <= slice_GT;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            EQ    <= slice_EQ;
            GT    <= slice_GT;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_lat  <= A;
            b_lat  <= B;
            idx    <= '0;
            acc_eq <= 1'b1;
            acc_gt <= 1'b0;
            state  <= S_RUN;
            busy   <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl: slice modelled behaviourally, expected results from plain arithmetic.
module tb_cmp_seq_ctrl;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, EQ, GT;
  logic [7:0]   slice_A, slice_B;
  logic         slice_eq, slice_gt;
  logic         slice_EQ, slice_GT;

  cmp_seq_ctrl #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .EQ(EQ), .GT(GT),
    .slice_A(slice_A), .slice_B(slice_B), .slice_eq(slice_eq), .slice_gt(slice_gt),
    .slice_EQ(slice_EQ), .slice_GT(slice_GT)
  );

  // External comparator slice
  assign slice_EQ = (slice_A == slice_B) & slice_eq;
  assign slice_GT = (slice_A > slice_B) | ((slice_A == slice_B) & slice_gt);

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq;
    logic         gt;
    int           due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_at = 0;
  int   checks = 0;
  int   failures = 0;
  logic held_eq = 1'b0;
  logic held_gt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.due = due;
    e.eq  = (a == b);
`ifdef SIGNED_EN
    e.gt  = ($signed(a) > $signed(b));
`else
    e.gt  = (a > b);
`endif
    return e;
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int j);
    logic [7:0] r;
    r = v[8*j +: 8];
`ifdef SIGNED_EN
    if (j == BYTES - 1) r[7] = ~r[7];
`endif
    return r;
  endfunction

  // One stimulus cycle; a start is accepted only when the controller is idle or in DONE.
  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    #1;
    start = st;
    A     = a;
    B     = b;
    if (st && cyc >= free_at) begin
      q.push_back(model(a, b, cyc + BYTES + 1));
      free_at = cyc + BYTES + 1;
    end
  endtask

  // Monitor: checks handshake timing, slice traffic and results every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      logic busy_exp, done_exp;
      int   j;
      busy_exp = (q.size() > 0) && (cyc >= q[0].due - BYTES) && (cyc < q[0].due);
      done_exp = (q.size() > 0) && (cyc == q[0].due);
      chk(busy == busy_exp, "busy", 64'(busy), 64'(busy_exp));
      chk(done == done_exp, "done", 64'(done), 64'(done_exp));
      if (busy_exp) begin
        j = cyc - (q[0].due - BYTES);
        chk(slice_A == byte_of(q[0].a, j), "slice_A", 64'(slice_A), 64'(byte_of(q[0].a, j)));
        chk(slice_B == byte_of(q[0].b, j), "slice_B", 64'(slice_B), 64'(byte_of(q[0].b, j)));
      end else begin
        chk({slice_A, slice_B, slice_eq, slice_gt} == 18'h00002, "slice_idle",
            64'({slice_A, slice_B, slice_eq, slice_gt}), 64'h2);
      end
      if (done_exp) begin
        held_eq = q[0].eq;
        held_gt = q[0].gt;
        void'(q.pop_front());
      end
      chk(EQ == held_eq, "EQ", 64'(EQ), 64'(held_eq));
      chk(GT == held_gt, "GT", 64'(GT), 64'(held_gt));
      chk(!(EQ && GT), "eq_gt_exclusive", 64'({EQ, GT}), 64'h0);
    end
  end

  task automatic reset_checks(input string tag);
    chk({busy, done, EQ, GT} == 4'b0000, {tag, "_outs"}, 64'({busy, done, EQ, GT}), 64'h0);
    chk({slice_A, slice_B, slice_eq, slice_gt} == 18'h00002, {tag, "_slice"},
        64'({slice_A, slice_B, slice_eq, slice_gt}), 64'h2);
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    for (int i = 0; i < BYTES; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Shares most bytes with a so the cascade path decides many results.
  function automatic logic [W-1:0] near_word(input logic [W-1:0] a);
    logic [W-1:0] v;
    v = a;
    for (int i = 0; i < BYTES; i++)
      if ($urandom_range(0, 2) == 0) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  logic [W-1:0] da [7];
  logic [W-1:0] db [7];

  initial begin
    da = '{32'h2E2E2E2E, 32'h2E2E2E2E, 32'h2E2E2E30, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    db = '{32'h2E2E2E2E, 32'h2E2E2E2F, 32'h2E2E2E2F, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};

    #3;
    reset_checks("por");
    @(negedge clk);
    #1 rst = 1'b0;
    free_at = cyc;

    // Directed operand pairs, one compare each with idle gaps
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, da[i], db[i]);
      for (int k = 0; k < BYTES + 2; k++) drive(1'b0, rnd_word(), rnd_word());
    end

    // start held high with operands changing every cycle: back-to-back, latched operands only
    for (int k = 0; k < 4 * (BYTES + 1) + 1; k++) drive(1'b1, rnd_word(), rnd_word());
    for (int k = 0; k < BYTES + 2; k++) drive(1'b0, '0, '0);

    // Second start pulse during RUN is ignored
    drive(1'b1, 32'h12345678, 32'h12345679);
    drive(1'b0, '0, '0);
    drive(1'b1, 32'hFFFFFFFF, 32'h00000000);
    for (int k = 0; k < BYTES + 2; k++) drive(1'b0, '0, '0);

    // Reset in RUN cycle 2, then a fresh compare
    drive(1'b1, 32'hDEADBEEF, 32'h00000000);
    drive(1'b0, '0, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    reset_checks("mid_rst");
    q.delete();
    held_eq = 1'b0;
    held_gt = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    free_at = cyc;
    drive(1'b1, 32'h00000001, 32'h00000001);
    for (int k = 0; k < BYTES + 2; k++) drive(1'b0, '0, '0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [W-1:0] a;
      a = rnd_word();
      drive(1'($urandom_range(0, 2) == 0), a, near_word(a));
    end
    for (int k = 0; k < BYTES + 3; k++) drive(1'b0, '0, '0);

    chk(q.size() == 0, "drain", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_seq_ctrl.md
# cmp_seq_ctrl

Sequencing controller that compares two multi-byte operands using a single external 8-bit cascadable magnitude-comparator slice. The slice has inputs A, B, eq, gt and outputs EQ, GT. The controller latches the operands on a start request and presents one byte pair per cycle, least-significant byte first. It feeds the accumulated result back into the slice's eq/gt cascade inputs and reports the final EQ/GT with a done pulse. It sits between the compare-request logic and the shared comparator slice, so wide compares cost one slice instead of a full-width comparator.

## Interface
- BYTES, 4: operand width in bytes; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  compare request.
- A  in  8*BYTES  operand A, unsigned (signed with SIGNED_EN).
- B  in  8*BYTES  operand B.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when EQ/GT become valid.
- EQ  out  1  final result, A == B.
- GT  out  1  final result, A > B.
- slice_A  out  8  byte of A presented to the slice.
- slice_B  out  8  byte of B presented to the slice.
- slice_eq  out  1  cascade eq input to the slice.
- slice_gt  out  1  cascade gt input to the slice.
- slice_EQ  in  1  slice EQ output; combinational in the same cycle.
- slice_GT  in  1  slice GT output.

## Operation
- Slice contract:
  - slice_EQ = (byteA == byteB) & slice_eq.
  - slice_GT = (byteA > byteB) | ((byteA == byteB) & slice_gt).
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0.
  - start=1 latches A and B into internal registers.
  - Sets idx=0, acc_eq=1, acc_gt=0.
  - Goes to RUN.
- RUN: busy=1.
  - slice_A = latched A[8*idx+7:8*idx]; slice_B = latched B[8*idx+7:8*idx].
  - slice_eq = acc_eq; slice_gt = acc_gt.
  - On each clock: acc_eq <= slice_EQ, acc_gt <= slice_GT, idx <= idx+1.
  - After the cycle with idx = BYTES-1, goes to DONE.
- DONE: lasts exactly one cycle.
  - busy=0, done=1.
  - EQ/GT are updated from acc_eq/acc_gt.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back compare, next state RUN); otherwise next state is IDLE.
- EQ/GT hold their value until the next DONE. They are not modified during a following RUN.
- start while in RUN is ignored.
- A/B changes after the start cycle have no effect on the compare in progress.
- Outside RUN, the slice ports are driven to slice_A=0, slice_B=0, slice_eq=1, slice_gt=0.
- Counter idx is $clog2(BYTES)+1 bits wide, so it never wraps inside a compare.
- BYTES=1: a single RUN cycle.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE; in-flight compare is discarded.
  - busy=0, done=0, EQ=0, GT=0.
  - slice_A=0, slice_B=0, slice_eq=1, slice_gt=0.
  - acc_eq=1, acc_gt=0, idx=0.
- Cycle 0: start sampled high in IDLE.
- Cycles 1..BYTES: RUN, busy=1.
- Cycle BYTES+1: done=1 and EQ/GT valid.
- Latency from start to done is BYTES+1 clocks.
- Throughput: one compare per BYTES+1 clocks, using DONE-cycle restart.
- All outputs are registered except slice_A, slice_B, slice_eq and slice_gt. These four decode combinationally from registered state and idx only, never from slice_EQ/slice_GT, so no combinational loop exists.
- Invariant: EQ and GT are never both 1.

## Configuration
- SIGNED_EN defined:
  - Operands are two's complement.
  - When idx = BYTES-1, the controller drives slice_A[7] = ~A_lat[8*BYTES-1] and slice_B[7] = ~B_lat[8*BYTES-1], an offset-binary conversion, so GT means signed A > B.
- SIGNED_EN undefined: unsigned compare, bytes passed unmodified.
- EQ behaviour is identical in both builds.

## Test plan
- Reset mid-compare: assert rst in RUN cycle 2 → busy, done, EQ and GT are 0 immediately. After release, start with A=B=0x0000_0001 gives done at cycle 5 with EQ=1.
- BYTES=4, A=B=0x2E2E2E2E, start pulse → busy in cycles 1–4, done=1 in cycle 5 only, EQ=1, GT=0. Slice sees 0x2E/0x2E each RUN cycle.
- A=0x2E2E2E2E, B=0x2E2E2E2F → EQ=0, GT=0. Then A=0x2E2E2E30 with the same B → EQ=0, GT=1; the LSB decides when the upper bytes are equal.
- A=0x80000000, B=0x7FFFFFFF:
  - Unsigned build: GT=1, EQ=0.
  - With SIGNED_EN: GT=0, EQ=0.
  - A=0xFFFFFFFF, B=0x00000001 with SIGNED_EN: GT=0.
- Handshake edges:
  - start held high continuously → done every 5 cycles, busy never high in the DONE cycle.
  - A second start pulse in RUN cycle 2 is ignored; exactly one done.
  - Change A in cycle 2 → result reflects the A latched in cycle 0.
